uart_word_packer: RTL
=====================

Name: uart_word_packer

Overview:
- Sits between the UART byte receiver and the SDRAM write-side FIFO in the UART-to-SDRAM-to-VGA image path.
- Packs pairs of received bytes into 16-bit SDRAM words and issues single-cycle FIFO write strobes with FIFO-full backpressure.
- Tracks word position within a frame and flags frame completion.
- Drops a stale half-word after an inter-byte timeout so byte pairing resynchronises after a line glitch.

Parameters:
- DATA_W, 16, output word width; fixed at 2 bytes.
- FRAME_WORDS, 153600, words per frame (640x480 RGB332 pixels, two per word).
- TIMEOUT_CYCLES, 50000, Sys_clk cycles allowed between low and high byte (1 ms at 50 MHz).
- CNT_W, $clog2(FRAME_WORDS), width of the word counter.

Ports:
- Sys_clk  in  1  system clock, 50 MHz.
- Rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous clear of pairing state, counters and flags.
- rx_data  in  8  received byte; valid only while rx_done=1.
- rx_done  in  1  single-cycle byte-valid pulse.
- fifo_full  in  1  SDRAM write FIFO full.
- FIFO_WR_EN  out  1  write strobe, one cycle per word.
- FIFO_WR_data  out  16  packed word; first byte in [7:0], second byte in [15:8].
- frame_done  out  1  one-cycle pulse coincident with the FIFO_WR_EN of word FRAME_WORDS-1.
- word_cnt  out  CNT_W  words written in the current frame.
- overflow  out  1  sticky: a completed word was dropped because the previous word was still pending.
- resync_err  out  1  one-cycle pulse when a half-word is discarded on timeout.

Behaviour:
- Reset (async, Rst_n=0) and soft_clr: FSM=S_LO; FIFO_WR_EN=0; FIFO_WR_data=0; frame_done=0; word_cnt=0; overflow=0; resync_err=0; pending=0; timer=0.
- FSM states:
  - S_LO: on rx_done, latch lo_reg<=rx_data, clear timer, go to S_HI.
  - S_HI: timer increments each cycle without rx_done.
    - On rx_done, form word {rx_data, lo_reg} and go to S_LO.
    - When timer reaches TIMEOUT_CYCLES-1 with no rx_done: discard lo_reg, pulse resync_err, go to S_LO.
    - rx_done in the same cycle as timeout: the byte wins as the high byte; no resync_err.
- Output holding register:
  - A completed word loads the holding register and sets pending=1.
  - FIFO_WR_EN is registered: it asserts for one cycle on the first cycle with pending=1 and fifo_full=0. pending clears in that same cycle.
  - Latency: FIFO_WR_EN is high on the cycle after the second rx_done when fifo_full=0.
  - If fifo_full stays high, the word is held indefinitely; FIFO_WR_data remains stable until written.
  - A new word completing while pending=1 is dropped, overflow is set (sticky until reset or soft_clr), and the held word is kept.
  - Word completing in the same cycle the held word is written: the new word loads, pending stays 1, no overflow.
- Frame counting:
  - word_cnt increments on each FIFO_WR_EN.
  - On the write with word_cnt=FRAME_WORDS-1, frame_done pulses and word_cnt wraps to 0.
- soft_clr has priority over all other events in its cycle; a word pending at soft_clr is discarded and not written.
- rx_done pulses arrive no closer than 2 cycles apart; the block is not required to handle back-to-back pulses.

Decomposition:
- Shared package uart_sdram_pkg: FRAME_WORDS, TIMEOUT_CYCLES, state encodings S_LO/S_HI, byte-order constant.
- One sub-module, byte_gap_timer: counter with clear and enable; asserts expire at TIMEOUT_CYCLES-1.

Test Plan:
- Bytes 0x34 then 0x12, fifo_full=0 -> FIFO_WR_EN one cycle after second rx_done, FIFO_WR_data=0x1234, word_cnt=1.
- Byte 0xAA, then silence for TIMEOUT_CYCLES, then 0x11, 0x22 -> resync_err pulses once; single write of 0x2211.
- fifo_full=1 while 0x0201 completes, release after 100 cycles -> FIFO_WR_EN on first non-full cycle, data 0x0201, overflow=0.
- fifo_full held; words 0x0201 then 0x0403 complete -> overflow=1; after release only 0x0201 is written.
- FRAME_WORDS=4 override; send 8 bytes -> frame_done coincides with 4th FIFO_WR_EN; word_cnt returns to 0.
- Assert Rst_n=0 between low and high byte, then send 0x56, 0x78 -> no write from the stale byte; write 0x7856.

Source files
------------

// File: rtl/uart_sdram_pkg.sv
// Shared definitions for the UART-to-SDRAM image path: frame geometry,
// inter-byte timeout, byte-pairing states and word byte order.
package uart_sdram_pkg;

    localparam int DATA_W              = 16;
    localparam int FRAME_WORDS_DFLT    = 153600;  // 640x480 RGB332, two pixels per word
    localparam int TIMEOUT_CYCLES_DFLT = 50000;   // 1 ms at 50 MHz

    // First received byte lands in the low half of the word.
    localparam bit LO_BYTE_FIRST = 1'b1;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } pack_state_e;

    function automatic logic [DATA_W-1:0] pack_word(input logic [7:0] first_b,
                                                    input logic [7:0] second_b);
        return LO_BYTE_FIRST ? {second_b, first_b} : {first_b, second_b};
    endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles while waiting for the second byte of a word; expire
// is high while the count sits at TIMEOUT_CYCLES-1.
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int W              = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/uart_word_packer.sv
// Pairs UART bytes into 16-bit SDRAM words, writes them to the SDRAM FIFO
// under full backpressure, counts words per frame and resyncs on byte gaps.
module uart_word_packer
    import uart_sdram_pkg::*;
#(
    parameter int FRAME_WORDS    = FRAME_WORDS_DFLT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int CNT_W          = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic              Sys_clk,
    input  logic              Rst_n,
    input  logic              soft_clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              fifo_full,
    output logic              FIFO_WR_EN,
    output logic [DATA_W-1:0] FIFO_WR_data,
    output logic              frame_done,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              overflow,
    output logic              resync_err
);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    pack_state_e       state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              resync_q, resync_d;

    logic              tmr_clr, tmr_en, tmr_expire;
    logic              word_done, timeout_hit;
    logic [DATA_W-1:0] new_word, wr_word;
    logic              write_now, frame_last;

    byte_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (Sys_clk),
        .rst_n  (Rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (soft_clr) begin
            state_d = S_LO;
        end else begin
            case (state_q)
                S_LO:    if (rx_done) state_d = S_HI;
                S_HI:    if (rx_done || tmr_expire) state_d = S_LO;
                default: state_d = S_LO;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // A byte arriving on the expiry cycle still completes the word.
    always_comb begin
        word_done   = 1'b0;
        timeout_hit = 1'b0;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;
        lo_d        = lo_q;
        case (state_q)
            S_LO: begin
                if (rx_done) lo_d = rx_data;
            end
            S_HI: begin
                word_done   = rx_done;
                timeout_hit = !rx_done && tmr_expire;
                tmr_clr     = rx_done || tmr_expire;
                tmr_en      = !rx_done;
            end
            default: ;
        endcase
        if (soft_clr) begin
            word_done   = 1'b0;
            timeout_hit = 1'b0;
            tmr_clr     = 1'b1;
            tmr_en      = 1'b0;
            lo_d        = '0;
        end
    end

    // ---------------- holding register, write strobe, frame count ----------------
    assign new_word   = pack_word(lo_q, rx_data);
    assign write_now  = !fifo_full && (pending_q || word_done);
    assign wr_word    = pending_q ? hold_q : new_word;
    assign frame_last = (cnt_q == LAST_WORD);

    always_comb begin
        pending_d    = pending_q;
        hold_d       = hold_q;
        overflow_d   = overflow_q;
        data_d       = data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        resync_d     = timeout_hit;

        // A word that finds the FIFO free and nothing queued skips the hold stage.
        if (word_done) begin
            if (pending_q && fifo_full) begin
                overflow_d = 1'b1;
            end else if (pending_q || fifo_full) begin
                hold_d    = new_word;
                pending_d = 1'b1;
            end
        end else if (pending_q && !fifo_full) begin
            pending_d = 1'b0;
        end

        if (write_now) begin
            wr_en_d      = 1'b1;
            data_d       = wr_word;
            frame_done_d = frame_last;
            cnt_d        = frame_last ? '0 : cnt_q + 1'b1;
        end

        if (soft_clr) begin
            pending_d    = 1'b0;
            hold_d       = '0;
            overflow_d   = 1'b0;
            data_d       = '0;
            wr_en_d      = 1'b0;
            frame_done_d = 1'b0;
            cnt_d        = '0;
            resync_d     = 1'b0;
        end
    end

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lo_q         <= '0;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            lo_q         <= lo_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            data_q       <= data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            resync_q     <= resync_d;
        end
    end

    assign FIFO_WR_EN   = wr_en_q;
    assign FIFO_WR_data = data_q;
    assign frame_done   = frame_done_q;
    assign word_cnt     = cnt_q;
    assign overflow     = overflow_q;
    assign resync_err   = resync_q;

endmodule
